asym_fifo: RTL and testbench
============================

Name: asym_fifo

Overview:
- Parametrised asymmetric FIFO: wide write port, narrow read port. Write word width is RATIO × DATA_WIDTH; read word width is DATA_WIDTH.
- Next-generation asymmetric buffer. Generalises the fixed 2:1 split to any power-of-two ratio.
- Adds full/empty/count status and overflow/underflow error pulses.
- Sits between a wide producer (e.g. a 16-bit data path) and a narrow consumer (e.g. a byte-serial UART TX).

Parameters:
- DATA_WIDTH, 8: narrow (read) word width in bits.
- RATIO, 2: narrow words per write word. Legal values: 1, 2, 4, 8.
- ADDR_WIDTH, 3: log2 of storage depth in narrow words. DEPTH = 2**ADDR_WIDTH. DEPTH must be ≥ 2*RATIO.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr  input  1  write request.
- w_data  input  RATIO*DATA_WIDTH  write word.
- rd  input  1  read request; pops one narrow word.
- r_data  output  DATA_WIDTH  head-of-FIFO narrow word (first-word-fall-through).
- full  output  1  fewer than RATIO free narrow slots.
- empty  output  1  no stored narrow words.
- count  output  ADDR_WIDTH+1  number of stored narrow words, 0..DEPTH.
- w_err  output  1  one-cycle pulse: write rejected.
- r_err  output  1  one-cycle pulse: read rejected.

Behaviour:
- Storage: DEPTH × DATA_WIDTH array, not reset. Written synchronously; read combinationally.
- Registered state: w_ptr, r_ptr (ADDR_WIDTH bits each), count, w_err, r_err.
- Reset (asynchronous, immediate): w_ptr=0, r_ptr=0, count=0, w_err=0, r_err=0. Hence empty=1, full=0, r_data=0.
- full = (count > DEPTH-RATIO). empty = (count == 0). Both are combinational from count.
- Write acceptance: wr_ok = wr & ~full, evaluated on the pre-edge state.
- On wr_ok: mem[w_ptr+i] <= w_data slice i, for i=0..RATIO-1.
  - Slice 0 is the most-significant DATA_WIDTH bits, so the MS part is read first.
  - w_ptr advances by RATIO, modulo DEPTH.
- Read acceptance: rd_ok = rd & ~empty. On rd_ok, r_ptr advances by 1, modulo DEPTH.
- r_data = empty ? 0 : mem[r_ptr]. Zero-latency view of the head; a written word is visible the cycle after the write edge.
- count_next = count + (wr_ok ? RATIO : 0) - (rd_ok ? 1 : 0).
- Simultaneous wr and rd: each is judged independently on pre-edge full/empty.
  - A write is rejected when full, even if a concurrent read frees space. No bypass.
  - A read on empty is rejected, even if a concurrent write arrives. No write-through.
- w_err <= wr & full; r_err <= rd & empty. Both are registered, high exactly one cycle per offending request, and leave pointers/count unchanged.
- Wrap-around: DEPTH is a multiple of RATIO and w_ptr is always RATIO-aligned, so a write word never straddles the wrap point. r_ptr wraps freely.
- Reset mid-operation: all contents are discarded logically. The first post-reset write lands at address 0.
- RATIO=1 degenerates to a symmetric FIFO; all rules still hold.

Test Plan (DATA_WIDTH=8, RATIO=2, ADDR_WIDTH=3, DEPTH=8):
1. Assert reset, release -> empty=1, full=0, count=0, r_data=8'h00, w_err=0, r_err=0.
2. Write 16'hA1B2 -> next cycle count=2, r_data=8'hA1. rd -> r_data=8'hB2, count=1. rd -> empty=1, count=0. Extra rd -> r_err high one cycle, count stays 0.
3. Write 16'h0102, 16'h0304, 16'h0506, 16'h0708 -> count=8, full=1. Write 16'hFFFF -> w_err pulse, count=8. Eight reads -> 01,02,…,08, then empty=1.
4. Four writes, one read -> count=7, full=1 (free slot 1 < RATIO). wr and rd in the same cycle -> read accepted, write rejected with w_err, count=6, full=0.
5. Stream 20 write words (16'h0000+k) with interleaved reads keeping count ≤6 -> the 40 bytes emerge in order, MS byte first, across multiple pointer wraps. No w_err or r_err.
6. With count=5, assert reset asynchronously mid-cycle -> count=0 and empty=1 before the next clk edge. Then write 16'hC3D4 -> r_data=8'hC3, read from address 0.

Source files
------------

// File: rtl/asym_fifo.sv
// ============================================================================
// Module   : asym_fifo
// Brief    : Wide-write / narrow-read FWFT FIFO, MS narrow word read first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module asym_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 2,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr,
  input  logic [RATIO*DATA_WIDTH-1:0] w_data,
  input  logic                        rd,
  output logic [DATA_WIDTH-1:0]       r_data,
  output logic                        full,
  output logic                        empty,
  output logic [ADDR_WIDTH:0]         count,
  output logic                        w_err,
  output logic                        r_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_THRESH = (ADDR_WIDTH+1)'(DEPTH - RATIO);
  localparam logic [ADDR_WIDTH:0]   RATIO_CNT   = (ADDR_WIDTH+1)'(RATIO);
  localparam logic [ADDR_WIDTH-1:0] RATIO_PTR   = ADDR_WIDTH'(RATIO);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] w_slice [RATIO];

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  w_err_q, w_err_d;
  logic                  r_err_q, r_err_d;
  logic                  wr_ok, rd_ok;

  // Slice 0 is the most-significant part of the write word.
  generate
    for (genvar i = 0; i < RATIO; i++) begin : g_slice
      assign w_slice[i] = w_data[(RATIO-1-i)*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign full  = (count_q > FULL_THRESH);
  assign empty = (count_q == '0);
  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    w_err_d = wr & full;
    r_err_d = rd & empty;
    if (wr_ok) begin
      w_ptr_d = w_ptr_q + RATIO_PTR;
    end
    if (rd_ok) begin
      r_ptr_d = r_ptr_q + 1'b1;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + RATIO_CNT;
      2'b01:   count_d = count_q - 1'b1;
      2'b11:   count_d = count_q + RATIO_CNT - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      w_err_q <= 1'b0;
      r_err_q <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      w_err_q <= w_err_d;
      r_err_q <= r_err_d;
    end
  end

  // w_ptr is RATIO-aligned, so w_ptr+i never crosses the wrap point.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < RATIO; i++) begin
        mem[w_ptr_q + ADDR_WIDTH'(i)] <= w_slice[i];
      end
    end
  end

  assign r_data = empty ? '0 : mem[r_ptr_q];
  assign count  = count_q;
  assign w_err  = w_err_q;
  assign r_err  = r_err_q;

endmodule

`default_nettype wire

// File: tb/tb_asym_fifo.sv
// ============================================================================
// Module   : tb_asym_fifo
// Brief    : Directed self-checking bench for asym_fifo (8-bit, 2:1, depth 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_asym_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic [15:0] w_data;
  logic        rd;
  logic [7:0]  r_data;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        w_err;
  logic        r_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q [$];
  logic       err_seen;

  asym_fifo #(.DATA_WIDTH(8), .RATIO(2), .ADDR_WIDTH(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .w_data (w_data),
    .rd     (rd),
    .r_data (r_data),
    .full   (full),
    .empty  (empty),
    .count  (count),
    .w_err  (w_err),
    .r_err  (r_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] d);
    wr = 1'b1; w_data = d; rd = 1'b0;
    step();
    wr = 1'b0;
  endtask

  task automatic read_byte(input string tag, input logic [7:0] exp);
    check(tag, {24'h0, r_data}, {24'h0, exp});
    rd = 1'b1; wr = 1'b0;
    step();
    rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = '0;
    step(); step();
    reset = 1'b0;
    step();

    // 1: reset state
    check("rst_empty", {31'h0, empty}, 32'd1);
    check("rst_full",  {31'h0, full},  32'd0);
    check("rst_count", {28'h0, count}, 32'd0);
    check("rst_rdata", {24'h0, r_data}, 32'h00);
    check("rst_werr",  {31'h0, w_err}, 32'd0);
    check("rst_rerr",  {31'h0, r_err}, 32'd0);

    // 2: single word, MS byte first, then underflow
    write_word(16'hA1B2);
    check("t2_count2", {28'h0, count}, 32'd2);
    check("t2_rdA1",   {24'h0, r_data}, 32'hA1);
    rd = 1'b1;
    step();
    check("t2_rdB2",   {24'h0, r_data}, 32'hB2);
    check("t2_count1", {28'h0, count}, 32'd1);
    step();
    check("t2_empty",  {31'h0, empty}, 32'd1);
    check("t2_count0", {28'h0, count}, 32'd0);
    check("t2_rerr0",  {31'h0, r_err}, 32'd0);
    step();
    check("t2_rerr1",  {31'h0, r_err}, 32'd1);
    check("t2_cnt_ue", {28'h0, count}, 32'd0);
    rd = 1'b0;
    step();
    check("t2_rerr_pulse", {31'h0, r_err}, 32'd0);

    // 3: fill, overflow, drain
    write_word(16'h0102);
    write_word(16'h0304);
    write_word(16'h0506);
    write_word(16'h0708);
    check("t3_count8", {28'h0, count}, 32'd8);
    check("t3_full",   {31'h0, full},  32'd1);
    check("t3_werr0",  {31'h0, w_err}, 32'd0);
    write_word(16'hFFFF);
    check("t3_werr1",  {31'h0, w_err}, 32'd1);
    check("t3_cnt_ov", {28'h0, count}, 32'd8);
    step();
    check("t3_werr_pulse", {31'h0, w_err}, 32'd0);
    for (int i = 1; i <= 8; i++) read_byte("t3_drain", 8'(i));
    check("t3_empty",  {31'h0, empty}, 32'd1);

    // 4: full with one free slot rejects write even alongside a read
    write_word(16'h1112);
    write_word(16'h1314);
    write_word(16'h1516);
    write_word(16'h1718);
    read_byte("t4_head", 8'h11);
    check("t4_count7", {28'h0, count}, 32'd7);
    check("t4_full7",  {31'h0, full},  32'd1);
    wr = 1'b1; rd = 1'b1; w_data = 16'hEEEE;
    step();
    wr = 1'b0; rd = 1'b0;
    check("t4_werr",   {31'h0, w_err}, 32'd1);
    check("t4_rerr",   {31'h0, r_err}, 32'd0);
    check("t4_count6", {28'h0, count}, 32'd6);
    check("t4_full6",  {31'h0, full},  32'd0);
    read_byte("t4_d13", 8'h13);
    read_byte("t4_d14", 8'h14);
    read_byte("t4_d15", 8'h15);
    read_byte("t4_d16", 8'h16);
    read_byte("t4_d17", 8'h17);
    read_byte("t4_d18", 8'h18);
    check("t4_empty",  {31'h0, empty}, 32'd1);

    // 5: streaming across several pointer wraps
    err_seen = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 20; k++) begin
      wr = 1'b1; w_data = 16'(k); rd = (k > 0);
      if (k > 0) check("t5_data", {24'h0, r_data}, {24'h0, exp_q[0]});
      step();
      if (k > 0) void'(exp_q.pop_front());
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(k));
      err_seen = err_seen | w_err | r_err;
      wr = 1'b0; rd = 1'b1;
      check("t5_data", {24'h0, r_data}, {24'h0, exp_q[0]});
      step();
      void'(exp_q.pop_front());
      err_seen = err_seen | w_err | r_err;
      rd = 1'b0;
    end
    check("t5_left", {28'h0, count}, 32'd1);
    read_byte("t5_last", 8'd19);
    check("t5_noerr", {31'h0, err_seen}, 32'd0);
    check("t5_empty", {31'h0, empty}, 32'd1);

    // 6: asynchronous reset mid-cycle, then first write lands at address 0
    write_word(16'h2122);
    write_word(16'h2324);
    write_word(16'h2526);
    read_byte("t6_head", 8'h21);
    check("t6_count5", {28'h0, count}, 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_cnt",   {28'h0, count}, 32'd0);
    check("t6_async_empty", {31'h0, empty}, 32'd1);
    check("t6_async_rdata", {24'h0, r_data}, 32'h00);
    #1;
    reset = 1'b0;
    step();
    write_word(16'hC3D4);
    check("t6_rdC3", {24'h0, r_data}, 32'hC3);
    check("t6_cnt2", {28'h0, count}, 32'd2);
    read_byte("t6_C3", 8'hC3);
    read_byte("t6_D4", 8'hD4);
    check("t6_empty", {31'h0, empty}, 32'd1);
    check("t6_addr0", {29'h0, dut.r_ptr_q}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
